// File: rtl/max6675_spi_responder.sv
// MAX6675 thermocouple converter stand-in: SPI mode-0 responder that serves the 16-bit
// {0, temp[11:0], open, id=0, 0} frame and emulates CS-triggered conversion timing.
module max6675_spi_responder #(
  parameter int unsigned CONV_CLKS = 32'd22_000_000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_CS,
  input  logic        i_SPI_Clk,
  output logic        o_SPI_MISO,
  output logic        o_MISO_OE,
  input  logic [11:0] i_temp,
  input  logic        i_open,
  output logic        o_conv_busy,
  output logic        o_frame_done
);

  localparam int unsigned CntW = $clog2(CONV_CLKS);
  localparam logic [CntW-1:0] CntLast = CntW'(CONV_CLKS - 1);

  typedef enum logic {ConvIdle, ConvRun} conv_state_e;
  typedef enum logic [1:0] {FrIdle, FrShift, FrDone} frame_state_e;

  // [0] first sync stage, [1] synced value, [2] previous synced value for edge detect
  logic [2:0] cs_sync_q, sck_sync_q;
  logic       cs_rise, cs_fall, sck_rise, sck_fall;

  conv_state_e    conv_state_q, conv_state_d;
  logic [CntW-1:0] conv_cnt_q, conv_cnt_d;
  logic [12:0]    result_q, result_d;

  frame_state_e frame_state_q, frame_state_d;
  logic [15:0]  shift_q, shift_d;
  logic [4:0]   rise_cnt_q, rise_cnt_d;
  logic [4:0]   fall_cnt_q, fall_cnt_d;

  logic miso_d, oe_d, done_d;

  // Synchronize the asynchronous SPI pins and keep one extra stage for edge detection
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      cs_sync_q  <= 3'b111;
      sck_sync_q <= 3'b000;
    end else begin
      cs_sync_q  <= {cs_sync_q[1:0], i_CS};
      sck_sync_q <= {sck_sync_q[1:0], i_SPI_Clk};
    end
  end

  assign cs_rise  =  cs_sync_q[1]  & ~cs_sync_q[2];
  assign cs_fall  = ~cs_sync_q[1]  &  cs_sync_q[2];
  assign sck_rise =  sck_sync_q[1] & ~sck_sync_q[2];
  assign sck_fall = ~sck_sync_q[1] &  sck_sync_q[2];

  // State registers for both FSMs; reset starts a fresh conversion
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      conv_state_q  <= ConvRun;
      conv_cnt_q    <= '0;
      result_q      <= '0;
      frame_state_q <= FrIdle;
      shift_q       <= '0;
      rise_cnt_q    <= '0;
      fall_cnt_q    <= '0;
    end else begin
      conv_state_q  <= conv_state_d;
      conv_cnt_q    <= conv_cnt_d;
      result_q      <= result_d;
      frame_state_q <= frame_state_d;
      shift_q       <= shift_d;
      rise_cnt_q    <= rise_cnt_d;
      fall_cnt_q    <= fall_cnt_d;
    end
  end

  // Conversion next state: CS fall aborts without updating the result, CS rise restarts
  always_comb begin
    conv_state_d = conv_state_q;
    conv_cnt_d   = conv_cnt_q;
    result_d     = result_q;
    case (conv_state_q)
      ConvIdle: ;
      ConvRun: begin
        if (cs_fall) begin
          conv_state_d = ConvIdle;
        end else if (conv_cnt_q == CntLast) begin
          conv_state_d = ConvIdle;
          result_d     = {i_temp, i_open};
        end else begin
          conv_cnt_d = conv_cnt_q + 1'b1;
        end
      end
      default: conv_state_d = ConvIdle;
    endcase
    if (cs_rise) begin
      conv_state_d = ConvRun;
      conv_cnt_d   = '0;
    end
  end

  // Frame next state: snapshot result on CS fall, shift on SCK fall, count SCK rises
  always_comb begin
    frame_state_d = frame_state_q;
    shift_d       = shift_q;
    rise_cnt_d    = rise_cnt_q;
    fall_cnt_d    = fall_cnt_q;
    case (frame_state_q)
      FrIdle: begin
        if (cs_fall) begin
          frame_state_d = FrShift;
          shift_d       = {1'b0, result_q, 2'b00};
          rise_cnt_d    = '0;
          fall_cnt_d    = '0;
        end
      end
      FrShift: begin
        if (sck_fall && (fall_cnt_q != 5'd16)) begin
          shift_d    = {shift_q[14:0], 1'b0};
          fall_cnt_d = fall_cnt_q + 5'd1;
        end
        if (sck_rise) begin
          rise_cnt_d = rise_cnt_q + 5'd1;
          if (rise_cnt_q == 5'd15) frame_state_d = FrDone;
        end
      end
      FrDone: ;
      default: frame_state_d = FrIdle;
    endcase
    // CS rise has priority over any SCK edge in the same cycle
    if (cs_rise) frame_state_d = FrIdle;
  end

  // Output decode; done pulses on the 16th rise unless CS rises in the same cycle
  always_comb begin
    oe_d   = (frame_state_q == FrShift);
    miso_d = oe_d & shift_q[15];
    done_d = (frame_state_q == FrShift) & sck_rise & ~cs_rise & (rise_cnt_q == 5'd15);
  end

  // Registered pin outputs
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      o_SPI_MISO   <= 1'b0;
      o_MISO_OE    <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_SPI_MISO   <= miso_d;
      o_MISO_OE    <= oe_d;
      o_frame_done <= done_d;
    end
  end

  assign o_conv_busy = (conv_state_q == ConvRun);

endmodule

// File: tb/tb_max6675_spi_responder.sv
// Bench for max6675_spi_responder: event-level reference model checked every cycle plus
// hand-computed frame words from an SPI mode-0 master.
module tb_max6675_spi_responder;

  localparam int unsigned ConvClks = 50;
  localparam int KCsRise = 0, KCsFall = 1, KSckRise = 2, KSckFall = 3;
  localparam int FIdle = 0, FShift = 1, FDone = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cs;
  logic        sck;
  logic        miso, oe, busy, done;
  logic [11:0] temp;
  logic        open_f;

  max6675_spi_responder #(.CONV_CLKS(ConvClks)) dut (
    .i_clk       (clk),
    .i_reset     (reset_n),
    .i_CS        (cs),
    .i_SPI_Clk   (sck),
    .o_SPI_MISO  (miso),
    .o_MISO_OE   (oe),
    .i_temp      (temp),
    .i_open      (open_f),
    .o_conv_busy (busy),
    .o_frame_done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Pin changes take effect on the FSMs two edges after the edge that first samples them;
  // MISO/OE follow the frame state one edge later, busy and done follow immediately.
  int          cyc = 0;
  bit          m_valid = 1'b0;
  logic [12:0] m_result;
  int          m_conv_left;
  int          m_fstate;
  logic [15:0] m_word;
  int          m_rises;
  logic        m_cs_last, m_sck_last;
  int          ev_at[$];
  int          ev_kind[$];
  logic        e_miso, e_oe, e_busy, e_done;

  always @(posedge clk) begin : model
    bit cs_r, cs_f, sk_r, sk_f, conv_touched;
    int pre;
    cyc++;
    if (reset_n === 1'b0) begin
      m_valid     = 1'b1;
      m_result    = '0;
      m_conv_left = ConvClks;
      m_fstate    = FIdle;
      m_word      = '0;
      m_rises     = 0;
      m_cs_last   = 1'b1;
      m_sck_last  = 1'b0;
      ev_at.delete();
      ev_kind.delete();
      e_miso = 1'b0;
      e_oe   = 1'b0;
      e_done = 1'b0;
    end else if (m_valid) begin
      e_oe   = (m_fstate == FShift);
      e_miso = e_oe & m_word[15];
      e_done = 1'b0;
      if (cs != m_cs_last) begin
        ev_at.push_back(cyc + 2);
        ev_kind.push_back(cs ? KCsRise : KCsFall);
      end
      if (sck != m_sck_last) begin
        ev_at.push_back(cyc + 2);
        ev_kind.push_back(sck ? KSckRise : KSckFall);
      end
      m_cs_last  = cs;
      m_sck_last = sck;
      cs_r = 0; cs_f = 0; sk_r = 0; sk_f = 0; conv_touched = 0;
      while (ev_at.size() > 0 && ev_at[0] == cyc) begin
        case (ev_kind[0])
          KCsRise:  cs_r = 1;
          KCsFall:  cs_f = 1;
          KSckRise: sk_r = 1;
          default:  sk_f = 1;
        endcase
        void'(ev_at.pop_front());
        void'(ev_kind.pop_front());
      end
      pre = m_fstate;
      if (cs_r) begin
        m_fstate     = FIdle;
        m_conv_left  = ConvClks;
        conv_touched = 1;
      end
      if (cs_f) begin
        if (m_conv_left > 0) begin
          m_conv_left  = 0;
          conv_touched = 1;
        end
        if (pre == FIdle) begin
          m_fstate = FShift;
          m_word   = {1'b0, m_result, 2'b00};
          m_rises  = 0;
        end
      end
      if (!cs_r && pre == FShift) begin
        if (sk_f) m_word = m_word << 1;
        if (sk_r) begin
          m_rises++;
          if (m_rises == 16) begin
            e_done   = 1'b1;
            m_fstate = FDone;
          end
        end
      end
      if (!conv_touched && m_conv_left > 0) begin
        m_conv_left--;
        if (m_conv_left == 0) m_result = {temp, open_f};
      end
    end
    e_busy = (m_conv_left > 0);
  end

  // Compare process: every cycle once the model has seen reset
  always @(negedge clk) begin
    if (m_valid) begin
      chk("miso", {31'd0, miso}, {31'd0, e_miso});
      chk("oe",   {31'd0, oe},   {31'd0, e_oe});
      chk("busy", {31'd0, busy}, {31'd0, e_busy});
      chk("done", {31'd0, done}, {31'd0, e_done});
      if (done === 1'b1) done_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_idle();
    int n = 0;
    repeat (4) @(negedge clk);
    while (busy !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, expected 0", busy, n);
    end
  endtask

  // Mode-0 master: sample MISO as SCK rises, shift on fall; called at a negedge
  task automatic spi_read(input int nbits, input int half, input int lead, input bit raise_cs,
                          output logic [31:0] data);
    data = '0;
    cs = 1'b0;
    repeat (lead) @(negedge clk);
    for (int b = 0; b < nbits; b++) begin
      data = {data[30:0], miso};
      sck = 1'b1;
      repeat (half) @(negedge clk);
      sck = 1'b0;
      repeat (half) @(negedge clk);
    end
    if (raise_cs) cs = 1'b1;
  endtask

  logic [31:0] data;
  int d0;

  initial begin
    cs = 1'b1; sck = 1'b0; reset_n = 1'b0; temp = 12'h0C8; open_f = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    chk("reset_busy", {31'd0, busy}, 32'd1);
    chk("reset_oe",   {31'd0, oe},   32'd0);
    chk("reset_miso", {31'd0, miso}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);

    wait_idle();
    d0 = done_cnt;
    spi_read(16, 13, 6, 1'b1, data);
    chk("read_0640", {16'd0, data[15:0]}, 32'h0640);
    chk("done_once_16", done_cnt - d0, 32'd1);

    open_f = 1'b1;
    wait_idle();
    spi_read(16, 13, 6, 1'b1, data);
    chk("read_0644", {16'd0, data[15:0]}, 32'h0644);

    temp = 12'hFFF; open_f = 1'b0;
    wait_idle();
    spi_read(16, 13, 6, 1'b1, data);
    chk("read_7ff8", {16'd0, data[15:0]}, 32'h7FF8);

    temp = 12'h0C8;
    wait_idle();
    d0 = done_cnt;
    spi_read(24, 13, 6, 1'b1, data);
    chk("read24_b0", {24'd0, data[23:16]}, 32'h06);
    chk("read24_b1", {24'd0, data[15:8]},  32'h40);
    chk("read24_b2", {24'd0, data[7:0]},   32'h00);
    chk("done_once_24", done_cnt - d0, 32'd1);

    // CS low 20 cycles into a conversion aborts it; the old result is served
    temp = 12'h123;
    repeat (20) @(negedge clk);
    spi_read(16, 13, 6, 1'b1, data);
    chk("abort_conv_old", {16'd0, data[15:0]}, 32'h0640);
    wait_idle();
    spi_read(16, 13, 6, 1'b1, data);
    chk("read_0918", {16'd0, data[15:0]}, 32'h0918);

    // Frame aborted after 8 clocks
    wait_idle();
    d0 = done_cnt;
    spi_read(8, 13, 6, 1'b1, data);
    repeat (4) @(negedge clk);
    chk("abort_oe",   {31'd0, oe},   32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd1);
    chk("abort_byte", {24'd0, data[7:0]}, 32'h09);
    chk("abort_no_done", done_cnt - d0, 32'd0);

    // Reset mid-frame (CS released together with reset): result clears, conversion restarts
    wait_idle();
    spi_read(8, 13, 6, 1'b0, data);
    reset_n = 1'b0;
    cs = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    chk("midrst_miso", {31'd0, miso}, 32'd0);
    chk("midrst_oe",   {31'd0, oe},   32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd1);
    repeat (10) @(negedge clk);
    spi_read(16, 13, 6, 1'b1, data);
    chk("read_after_reset", {16'd0, data[15:0]}, 32'h0000);

    // Randomized reads: lengths, SCK rates, CS timing relative to conversions
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        temp   = 12'($urandom);
        open_f = 1'($urandom_range(0, 1));
      end
      repeat ($urandom_range(0, 80)) @(negedge clk);
      spi_read(int'($urandom_range(1, 24)), int'($urandom_range(6, 13)),
               int'($urandom_range(6, 12)), 1'b1, data);
    end

    wait_idle();
    repeat (10) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
    $fatal(1, "watchdog");
  end

endmodule
